// File: rtl/rgb_cmd_decoder_pkg.sv
// Shared types and helpers for the LED command frame decoder.
package rgb_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StB1,
    StB2,
    StChk,
    StApply
  } state_e;

  localparam logic [7:0] HdrDefault = 8'hA5;
  localparam int unsigned FrameLen = 4;

  // Frame check byte: XOR of header and both payload bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2);
    return hdr ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/rgb_cmd_decoder_if.sv
// Byte-stream handshake between the host front end and the command decoder.
interface rgb_cmd_decoder_if;

  logic [7:0] din;
  logic       dvalid;
  logic       dready;

  modport master (
    output din,
    output dvalid,
    input  dready
  );

  modport slave (
    input  din,
    input  dvalid,
    output dready
  );

endinterface

// File: rtl/rgb_cmd_decoder_timeout.sv
// Inter-byte idle counter; expire marks the idle cycle on which the count reaches TIMEOUT_CYC.
module rgb_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 27000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A byte accepted in the same cycle holds en low, so the byte wins over the timeout.
  assign expire = (TIMEOUT_CYC != 0) && en && (cnt_q == CntLast);

endmodule

// File: rtl/rgb_cmd_decoder.sv
// Parses A5/B1/B2/CHK command frames into LED parameter registers with a PARAMSOK strobe.
// Optional status outputs (frame_err, errcnt) are built when RGB_CMD_STATUS_EN is defined.
module rgb_cmd_decoder
  import rgb_cmd_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = HdrDefault,
  parameter int unsigned TIMEOUT_CYC = 27000,
  parameter logic [3:0]  RST_COLOR   = 4'h0,
  parameter logic [3:0]  RST_BRIGHT  = 4'h0
) (
  input  logic                clk,
  input  logic                rst,
  rgb_cmd_decoder_if.slave    bus,
  output logic [3:0]          rgbcolor,
  output logic [3:0]          brightness,
  output logic [3:0]          breathramp,
  output logic [3:0]          blinkrate,
  output logic                paramsok
`ifdef RGB_CMD_STATUS_EN
  ,
  output logic                frame_err,
  output logic [7:0]          errcnt
`endif
);

  state_e     state_q;
  logic [7:0] b1_q;
  logic [7:0] b2_q;
  logic       dready_q;
  logic       accept;
  logic       in_frame;
  logic       expire;
  logic       chk_bad;
  logic       drop;

  assign bus.dready = dready_q;
  assign accept     = bus.dvalid && dready_q;
  assign in_frame   = state_q inside {StB1, StB2, StChk};

  rgb_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_frame || accept),
    .en     (in_frame && !accept),
    .expire (expire)
  );

  assign chk_bad = (bus.din != frame_chk(HDR_BYTE, b1_q, b2_q));
  assign drop    = expire || ((state_q == StChk) && accept && chk_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      b1_q       <= '0;
      b2_q       <= '0;
      dready_q   <= 1'b0;
      paramsok   <= 1'b0;
      rgbcolor   <= RST_COLOR;
      brightness <= RST_BRIGHT;
      breathramp <= 4'h0;
      blinkrate  <= 4'h0;
    end else begin
      paramsok <= 1'b0;
      dready_q <= 1'b1;
      if (expire) begin
        state_q <= StIdle;
        b1_q    <= '0;
        b2_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // Non-header bytes between frames are dropped without flagging an error.
            if (accept && (bus.din == HDR_BYTE)) state_q <= StB1;
          end
          StB1: begin
            if (accept) begin
              b1_q    <= bus.din;
              state_q <= StB2;
            end
          end
          StB2: begin
            if (accept) begin
              b2_q    <= bus.din;
              state_q <= StChk;
            end
          end
          StChk: begin
            if (accept) begin
              if (chk_bad) begin
                state_q <= StIdle;
              end else begin
                // Outputs and strobe land together in the APPLY cycle.
                state_q                  <= StApply;
                dready_q                 <= 1'b0;
                paramsok                 <= 1'b1;
                {rgbcolor, brightness}   <= b1_q;
                {breathramp, blinkrate}  <= b2_q;
              end
            end
          end
          StApply: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef RGB_CMD_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      errcnt    <= 8'h00;
    end else begin
      frame_err <= drop;
      if (drop && (errcnt != 8'hFF)) errcnt <= errcnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_cmd_decoder.sv
// Directed bench for rgb_cmd_decoder (TIMEOUT_CYC=8, reset colour 2 / brightness 9).
module tb_rgb_cmd_decoder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rgb_cmd_decoder_if bus ();

  logic [3:0] rgbcolor;
  logic [3:0] brightness;
  logic [3:0] breathramp;
  logic [3:0] blinkrate;
  logic       paramsok;
  logic [15:0] par;
`ifdef RGB_CMD_STATUS_EN
  logic       frame_err;
  logic [7:0] errcnt;
`endif

  assign par = {rgbcolor, brightness, breathramp, blinkrate};

  rgb_cmd_decoder #(
    .HDR_BYTE    (8'hA5),
    .TIMEOUT_CYC (8),
    .RST_COLOR   (4'h2),
    .RST_BRIGHT  (4'h9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rgbcolor   (rgbcolor),
    .brightness (brightness),
    .breathramp (breathramp),
    .blinkrate  (blinkrate),
    .paramsok   (paramsok)
`ifdef RGB_CMD_STATUS_EN
    ,
    .frame_err  (frame_err),
    .errcnt     (errcnt)
`endif
  );

  // Drives a byte on a negedge once dready is high; it is taken at the following posedge.
  task automatic put(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.dready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dready) begin
      total++; bad++;
      $display("FAIL put_wait: dready low for 20 cycles, byte %h", b);
    end
    bus.din    = b;
    bus.dvalid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.dvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.dvalid = 1'b0; bus.din = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (bus.dready !== 1'b0) begin bad++; $display("FAIL rst_dready: got %b want 0", bus.dready); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.dready !== 1'b1) begin bad++; $display("FAIL rel_dready: got %b want 1", bus.dready); end
    total++;
    if (par !== 16'h2900) begin bad++; $display("FAIL rst_params: got %h want 2900", par); end
    total++;
    if (paramsok !== 1'b0) begin bad++; $display("FAIL rst_paramsok: got %b want 0", paramsok); end
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (errcnt !== 8'h00 || frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_status: got %h/%b want 00/0", errcnt, frame_err);
    end
`endif
  endtask

  task automatic test_valid_frame();
    put(8'hA5); put(8'h3C); put(8'h71); put(8'hE8);
    @(negedge clk);
    total++;
    if (par !== 16'h3C71) begin bad++; $display("FAIL frame_params: got %h want 3c71", par); end
    total++;
    if (paramsok !== 1'b1) begin bad++; $display("FAIL frame_strobe: got %b want 1", paramsok); end
    total++;
    if (bus.dready !== 1'b0) begin bad++; $display("FAIL apply_dready: got %b want 0", bus.dready); end
    bus.dvalid = 1'b0;
    @(negedge clk);
    total++;
    if (paramsok !== 1'b0 || bus.dready !== 1'b1) begin
      bad++; $display("FAIL after_apply: got ok=%b rdy=%b want 0/1", paramsok, bus.dready);
    end
    total++;
    if (par !== 16'h3C71) begin bad++; $display("FAIL hold_params: got %h want 3c71", par); end
  endtask

  task automatic test_bad_checksum();
    put(8'hA5); put(8'h5A); put(8'h96); put(8'h00);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (paramsok !== 1'b0) begin bad++; $display("FAIL badchk_strobe: got %b want 0", paramsok); end
    total++;
    if (par !== 16'h3C71) begin bad++; $display("FAIL badchk_params: got %h want 3c71", par); end
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (frame_err !== 1'b1 || errcnt !== 8'h01) begin
      bad++; $display("FAIL badchk_status: got %b/%h want 1/01", frame_err, errcnt);
    end
    @(negedge clk);
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL err_pulse: got %b want 0", frame_err); end
`endif
  endtask

  task automatic test_junk();
    put(8'h00); put(8'hFF); put(8'h12);
    put(8'hA5); put(8'h5A); put(8'h96); put(8'h69);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h5A96 || paramsok !== 1'b1) begin
      bad++; $display("FAIL junk_frame: got %h ok=%b want 5a96 ok=1", par, paramsok);
    end
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (errcnt !== 8'h01) begin bad++; $display("FAIL junk_errcnt: got %h want 01", errcnt); end
`endif
  endtask

  task automatic test_header_in_frame();
    put(8'hA5); put(8'hA5); put(8'h3C); put(8'h3C);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'hA53C || paramsok !== 1'b1) begin
      bad++; $display("FAIL hdr_data: got %h ok=%b want a53c ok=1", par, paramsok);
    end
  endtask

  task automatic test_back_to_back();
    put(8'hA5); put(8'h12); put(8'h34); put(8'h83);
    @(negedge clk);
    total++;
    if (par !== 16'h1234 || paramsok !== 1'b1) begin
      bad++; $display("FAIL b2b_first: got %h ok=%b want 1234 ok=1", par, paramsok);
    end
    put(8'hA5);
    total++;
    if (paramsok !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got %b want 0", paramsok); end
    put(8'h12); put(8'h34); put(8'h83);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h1234 || paramsok !== 1'b1) begin
      bad++; $display("FAIL b2b_repeat: got %h ok=%b want 1234 ok=1", par, paramsok);
    end
  endtask

  task automatic test_timeout();
    put(8'hA5); put(8'h3C);
    idle(8);
    @(negedge clk);
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (frame_err !== 1'b1 || errcnt !== 8'h02) begin
      bad++; $display("FAIL tmo_status: got %b/%h want 1/02", frame_err, errcnt);
    end
`endif
    put(8'h71); put(8'hE8);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h1234 || paramsok !== 1'b0) begin
      bad++; $display("FAIL tmo_ignored: got %h ok=%b want 1234 ok=0", par, paramsok);
    end
    // Byte arriving on the last allowed idle cycle must still be taken.
    put(8'hA5); put(8'h5A);
    idle(7);
    put(8'h96); put(8'h69);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h5A96 || paramsok !== 1'b1) begin
      bad++; $display("FAIL tmo_edge: got %h ok=%b want 5a96 ok=1", par, paramsok);
    end
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (errcnt !== 8'h02) begin bad++; $display("FAIL tmo_edge_cnt: got %h want 02", errcnt); end
`endif
  endtask

  task automatic test_mid_reset();
    put(8'hA5); put(8'h3C); put(8'h71);
    @(negedge clk);
    rst = 1'b1; bus.dvalid = 1'b0;
    @(negedge clk);
    total++;
    if (par !== 16'h2900 || paramsok !== 1'b0 || bus.dready !== 1'b0) begin
      bad++; $display("FAIL midrst: got %h ok=%b rdy=%b want 2900 0 0", par, paramsok, bus.dready);
    end
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (errcnt !== 8'h00) begin bad++; $display("FAIL midrst_cnt: got %h want 00", errcnt); end
`endif
    rst = 1'b0;
    put(8'hE8);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h2900 || paramsok !== 1'b0) begin
      bad++; $display("FAIL midrst_tail: got %h ok=%b want 2900 ok=0", par, paramsok);
    end
  endtask

  task automatic test_err_saturate();
`ifdef RGB_CMD_STATUS_EN
    localparam int NBad = 300;
`else
    localparam int NBad = 4;
`endif
    for (int i = 0; i < NBad; i++) begin
      put(8'hA5); put(8'h00); put(8'h00); put(8'h00);
    end
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h2900 || paramsok !== 1'b0) begin
      bad++; $display("FAIL sat_params: got %h ok=%b want 2900 ok=0", par, paramsok);
    end
`ifdef RGB_CMD_STATUS_EN
    total++;
    if (errcnt !== 8'hFF) begin bad++; $display("FAIL sat_errcnt: got %h want ff", errcnt); end
`endif
    put(8'hA5); put(8'h3C); put(8'h71); put(8'hE8);
    @(negedge clk);
    bus.dvalid = 1'b0;
    total++;
    if (par !== 16'h3C71 || paramsok !== 1'b1) begin
      bad++; $display("FAIL sat_recover: got %h ok=%b want 3c71 ok=1", par, paramsok);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_junk();
    test_header_in_frame();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_err_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
